packet_injector: RTL and testbench

//  Source-side transmitter for the router's address-flit protocol. It accepts one packet
//  (destination address + payload) as parallel words and serialises it into input_size-bit

---
 rtl/packet_injector_pkg.sv | 10 +
 rtl/packet_injector_if.sv | 24 ++
 rtl/packet_injector_flit_shift_reg.sv | 19 +
 rtl/packet_injector.sv | 67 ++++++
 tb/tb_packet_injector.sv | 134 +++++++++++++
 5 files changed

// File: rtl/packet_injector_pkg.sv
// packet_injector_pkg: shared widths, FSM state encoding and flit-count helper
package packet_injector_pkg;
  localparam int INPUT_SIZE = 4;
  localparam int ADDRESS_SIZE = 16;
  localparam int PAYLOAD_SIZE = 16;
  typedef enum logic [2:0] {IDLE, LAUNCH, ADDR, PAYLOAD, DONE} state_t;
  function automatic int flits(input int bits, input int w);
    return bits / w;
  endfunction
endpackage

// File: rtl/packet_injector_if.sv
// packet_injector_if: network-interface request side plus router-facing flit stream
interface packet_injector_if import packet_injector_pkg::*; #(
  parameter int IW = INPUT_SIZE,
  parameter int AW = ADDRESS_SIZE,
  parameter int PW = PAYLOAD_SIZE
);
  logic send_req;
  logic [AW-1:0] dest_address;
  logic [PW-1:0] payload;
  logic stall;
  logic send_ready;
  logic compute_address;
  logic flit_valid;
  logic [IW-1:0] flit_out;
  logic send_finish;
  modport master (
    output send_req, dest_address, payload, stall,
    input send_ready, compute_address, flit_valid, flit_out, send_finish
  );
  modport slave (
    input send_req, dest_address, payload, stall,
    output send_ready, compute_address, flit_valid, flit_out, send_finish
  );
endinterface

// File: rtl/packet_injector_flit_shift_reg.sv
// flit_shift_reg: parallel-load register shifting one flit left per enable, top flit exposed
module flit_shift_reg #(
  parameter int W = 32,
  parameter int F = 4
) (
  input logic clk,
  input logic reset,
  input logic i_load,
  input logic i_shift,
  input logic [W-1:0] i_data,
  output logic [F-1:0] o_top
);
  logic [W-1:0] r_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_data <= '0;
    else if (i_load) r_data <= i_data;
    else if (i_shift) r_data <= r_data << F;
  assign o_top = r_data[W-1 -: F];
endmodule

// File: rtl/packet_injector.sv
// packet_injector: serialises an address+payload packet into MSB-first flits for the router
module packet_injector import packet_injector_pkg::*; #(
  parameter int IW = INPUT_SIZE,
  parameter int AW = ADDRESS_SIZE,
  parameter int PW = PAYLOAD_SIZE
) (
  input logic clk,
  input logic reset,
  packet_injector_if.slave bus
);
  localparam int AF = flits(AW, IW);
  localparam int PF = flits(PW, IW);
  localparam int CW = $clog2(AF > PF ? AF : PF) + 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_load, w_shift;
  logic [IW-1:0] w_top;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
    end
  // address flits cannot pause; payload freezes counter and shifter on stall
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_load = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_load = bus.send_req;
        w_next = bus.send_req ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        w_next = bus.stall ? LAUNCH : ADDR;
        w_cnt = '0;
      end
      ADDR: begin
        w_shift = 1'b1;
        w_cnt = r_cnt == CW'(AF - 1) ? '0 : r_cnt + 1'b1;
        w_next = r_cnt == CW'(AF - 1) ? PAYLOAD : ADDR;
      end
      PAYLOAD: if (!bus.stall) begin
        w_shift = 1'b1;
        w_cnt = r_cnt == CW'(PF - 1) ? '0 : r_cnt + 1'b1;
        w_next = r_cnt == CW'(PF - 1) ? DONE : PAYLOAD;
      end
      default: w_next = IDLE;
    endcase
  end
  flit_shift_reg #(.W(AW + PW), .F(IW)) u_sr (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .i_shift(w_shift),
    .i_data({bus.dest_address, bus.payload}),
    .o_top(w_top)
  );
  assign bus.send_ready = r_state == IDLE || r_state == DONE;
  assign bus.compute_address = r_state == LAUNCH && !bus.stall;
  assign bus.flit_valid = r_state == ADDR || (r_state == PAYLOAD && !bus.stall);
  assign bus.flit_out = (r_state == ADDR || r_state == PAYLOAD) ? w_top : '0;
  assign bus.send_finish = r_state == DONE;
endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: directed and randomized packets checked against a timeline model
module tb_packet_injector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  packet_injector_if bus();
  packet_injector dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    return 4'((w >> (12 - 4 * k)) & 16'hF);
  endfunction

  function automatic logic [7:0] outs();
    return {bus.send_ready, bus.compute_address, bus.flit_valid, bus.send_finish, bus.flit_out};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed={rdy,ca,v,fin,flit}=%b required=%b", tag, obs, exp);
  endtask

  // cycle t=1 is the first cycle after the accepting edge; l launch stalls, payload
  // stall of pl cycles starting at payload slot ps, am = stall pattern during ADDR
  task automatic send(input logic [15:0] a, input logic [15:0] p, input int l, input int ps,
                      input int pl, input logic [3:0] am, input bit chain, input bit hold,
                      input logic [15:0] na, input logic [15:0] np, input int rst_at);
    int fin;
    int j;
    logic v;
    logic [3:0] o;
    fin = l + 10 + pl;
    if (!chain) begin
      @(negedge clk);
      bus.send_req = 1'b1;
      bus.dest_address = a;
      bus.payload = p;
      bus.stall = 1'b0;
      #1 chk("accept_ready", outs(), 8'h80);
    end
    for (int t = 1; t <= fin; t++) begin
      @(negedge clk);
      j = t - l - 6;
      bus.send_req = t == fin ? hold : 1'($urandom_range(0, 1));
      bus.dest_address = (t == fin && hold) ? na : 16'($urandom);
      bus.payload = (t == fin && hold) ? np : 16'($urandom);
      if (t <= l) bus.stall = 1'b1;
      else if (t == l + 1) bus.stall = 1'b0;
      else if (t < l + 6) bus.stall = am[t - l - 2];
      else if (t < fin) bus.stall = j >= ps && j < ps + pl;
      else bus.stall = 1'($urandom_range(0, 1));
      v = 1'b0;
      o = 4'h0;
      if (t >= l + 2 && t < l + 6) begin
        v = 1'b1;
        o = nib(a, t - l - 2);
      end else if (j >= 0 && t < fin) begin
        if (j < ps) begin
          v = 1'b1;
          o = nib(p, j);
        end else if (j < ps + pl) o = nib(p, ps);
        else begin
          v = 1'b1;
          o = nib(p, j - pl);
        end
      end
      if (t == rst_at) begin
        reset = 1'b0;
        #1 chk($sformatf("reset_mid t=%0d", t), outs(), 8'h80);
        return;
      end
      #1 chk($sformatf("pkt %h/%h t=%0d", a, p, t), outs(), {t == fin, t == l + 1, v, t == fin, o});
    end
    if (!hold) begin
      @(negedge clk);
      bus.send_req = 1'b0;
      bus.stall = 1'b0;
      #1 chk("back_to_idle", outs(), 8'h80);
    end
  endtask

  initial begin
    bit ch;
    bit h;
    logic [15:0] ca, cp, na, np;
    bus.send_req = 1'b1;
    bus.dest_address = 16'hFFFF;
    bus.payload = 16'hFFFF;
    bus.stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("reset_hold", outs(), 8'h80);
    end
    bus.send_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("post_reset_idle", outs(), 8'h80);
    end
    send(16'hA5C3, 16'h1234, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    send(16'hA5C3, 16'h1234, 3, 0, 0, 4'b0010, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    send(16'hA5C3, 16'h1234, 0, 1, 2, 4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    send(16'h9E17, 16'h4BD2, 0, 0, 0, 4'b1111, 1'b0, 1'b1, 16'h3C6F, 16'h8A01, 0);
    send(16'h3C6F, 16'h8A01, 0, 0, 0, 4'b0000, 1'b1, 1'b0, 16'h0, 16'h0, 0);
    send(16'h5A5A, 16'hFFFF, 1, 0, 0, 4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 5);
    bus.send_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 chk("mid_reset_hold", outs(), 8'h80);
    end
    @(negedge clk) reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1 chk("no_residual_flit", outs(), 8'h80);
    end
    ch = 1'b0;
    ca = 16'($urandom);
    cp = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      na = 16'($urandom);
      np = 16'($urandom);
      h = (i < 19) && ($urandom_range(0, 1) == 1);
      send(ca, cp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           4'($urandom), ch, h, na, np, 0);
      ch = h;
      ca = na;
      cp = np;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
